fp16_norm_sequencer: RTL and testbench
======================================

// Module: fp16_norm_sequencer
// PURPOSE
//  Iterative multi-cycle normalizer controller for the half-precision datapath. Accepts one raw
//  mantissa/exponent pair from the add/sub stage via valid/ready handshake and applies one
//  normalization step per cycle until normalized, subnormal, zero or overflowed. Presents the
//  result downstream (rounding/pack stage) with valid/ready. Sits between align/add and pack.
// PARAMETERS
//  MB   11  mantissa bits incl. hidden bit; IN_MANT[MB] is carry, IN_MANT[MB-1] is leading-one slot
//  EB   5   exponent bits; exponent buses are EB+1 wide (extra MSB kept clear in normal operation)
// PORTS
//  CLK            in   1      clock, rising edge
//  RST            in   1      asynchronous reset, active-high
//  IN_VALID       in   1      upstream operand valid
//  IN_READY       out  1      sequencer idle, can accept
//  IN_MANT        in   MB+1   raw mantissa (carry bit at [MB])
//  IN_EXP         in   EB+1   biased exponent
//  OUT_VALID      out  1      result valid, held until OUT_READY
//  OUT_READY      in   1      downstream accepts result
//  OUT_MANT       out  MB+1   normalized mantissa
//  OUT_EXP        out  EB+1   normalized biased exponent
//  OUT_OVF        out  1      overflow to infinity
//  OUT_DENORM     out  1      result is subnormal (exp field 0, mant nonzero)
//  SHIFT_CNT      out  4      left shifts applied to current op (saturates at 15)
// BEHAVIOUR
//  - States IDLE, NORM, DONE. Reset: state IDLE; IN_READY=1; OUT_VALID=0; OUT_MANT=0; OUT_EXP=0;
//    OUT_OVF=0; OUT_DENORM=0; SHIFT_CNT=0. Reset mid-operation aborts op; nothing emitted.
//  - IN_READY=1 only in IDLE. IDLE & IN_VALID: latch mant/exp, clear flags and SHIFT_CNT -> NORM.
//  - NORM, one step per cycle, priority order (EXP_MAX = 2^EB-1):
//    1 mant==0                    -> exp=0, DENORM=0 -> DONE
//    2 mant[MB], exp+1 < EXP_MAX  -> mant>>1, exp+1 -> DONE (carry is at most 1 bit)
//    3 mant[MB], exp+1 >= EXP_MAX -> mant=0, exp=EXP_MAX, OVF=1 -> DONE
//    4 !mant[MB-1], exp>1         -> mant<<1, exp-1, SHIFT_CNT+1 -> stay NORM
//    5 !mant[MB-1], exp<=1        -> exp=0, mant unchanged, DENORM=1 -> DONE
//    6 mant[MB-1]                 -> unchanged -> DONE
//  - Case 5 never shifts on exp 1->0 (subnormal scale equals exp 1).
//  - DONE: OUT_VALID=1; outputs and flags stable while OUT_READY=0. OUT_VALID&OUT_READY ->
//    IDLE (OUT_VALID=0 next cycle). No new accept in the same cycle as output handshake.
//  - Latency: OUT_VALID rises 2+N cycles after accepting edge, N = left shifts (N <= MB-1).
//  - Throughput: one op in flight; IN_VALID ignored outside IDLE.
//  - OUT_MANT/OUT_EXP mirror working registers; meaningful only while OUT_VALID=1.
//  - Input exp with MSB set (>= 2^EB) treated as case 3 whenever mant!=0.
// STRUCTURE
//  - Shared include fp16_defs.vh: MB/EB defaults, EXP_MAX, state encodings (IDLE/NORM/DONE).
//  - Sub-module fp16_norm_step: combinational single step (cases 1-6), outputs next mant/exp,
//    flags and a done bit; sequencer holds FSM, operand registers, counter, handshake.
// TESTING (MB=11, EB=5)
//  - IN_MANT=0x400 IN_EXP=15 -> OUT 0x400/15, SHIFT_CNT=0, flags 0, OUT_VALID 2 cycles post accept.
//  - IN_MANT=0x800 IN_EXP=15 -> OUT 0x400/16, latency 2, OVF=0.
//  - IN_MANT=0x010 IN_EXP=15 -> OUT 0x400/9, SHIFT_CNT=6, latency 8.
//  - IN_MANT=0x010 IN_EXP=3 -> OUT 0x040/0, DENORM=1, SHIFT_CNT=2; IN_MANT=0 -> 0x000/0, flags 0.
//  - IN_MANT=0x800 IN_EXP=30 -> OUT 0x000/31, OVF=1; OUT_READY low 5 cycles -> outputs held, IN_READY=0.
//  - Assert RST during NORM of 0x001/15 -> next cycle IDLE, IN_READY=1, OUT_VALID never pulses;
//    back-to-back ops after release normalize correctly.

Source files
------------

// File: rtl/fp16_norm_sequencer_pkg.sv
// Shared definitions for the half-precision normalizer sequencer.
// Holds the default datapath widths and the controller state encoding.
package fp16_norm_sequencer_pkg;

    localparam int DEF_MB = 11;
    localparam int DEF_EB = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp16_norm_sequencer_step.sv
// One combinational normalization step.
// Given the working mantissa/exponent, produces the next values, the flags and whether to stop.
module fp16_norm_sequencer_step
    import fp16_norm_sequencer_pkg::*;
#(
    parameter int MB = DEF_MB,
    parameter int EB = DEF_EB
) (
    input  logic [MB:0] mant,
    input  logic [EB:0] exp,
    output logic [MB:0] next_mant,
    output logic [EB:0] next_exp,
    output logic        ovf,
    output logic        denorm,
    output logic        shift,
    output logic        done
);

    localparam logic [EB:0] EXP_MAX = (EB+1)'((1 << EB) - 1);
    localparam logic [EB:0] EXP_ONE = (EB+1)'(1);

    logic [EB:0] exp_inc;

    assign exp_inc = exp + EXP_ONE;

    // An exponent with its spare MSB set can only mean overflow once the mantissa is nonzero.
    always_comb begin
        next_mant = mant;
        next_exp  = exp;
        ovf       = 1'b0;
        denorm    = 1'b0;
        shift     = 1'b0;
        done      = 1'b1;
        if (mant == '0) begin
            next_exp = '0;
        end else if (exp[EB] || (mant[MB] && (exp_inc >= EXP_MAX))) begin
            next_mant = '0;
            next_exp  = EXP_MAX;
            ovf       = 1'b1;
        end else if (mant[MB]) begin
            next_mant = mant >> 1;
            next_exp  = exp_inc;
        end else if (!mant[MB-1]) begin
            if (exp > EXP_ONE) begin
                next_mant = mant << 1;
                next_exp  = exp - EXP_ONE;
                shift     = 1'b1;
                done      = 1'b0;
            end else begin
                next_exp = '0;
                denorm   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp16_norm_sequencer.sv
// Iterative normalizer controller between the add/sub stage and the round/pack stage.
// Accepts one operand, applies one step per cycle, then holds the result until taken.
module fp16_norm_sequencer
    import fp16_norm_sequencer_pkg::*;
#(
    parameter int MB = DEF_MB,
    parameter int EB = DEF_EB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MB:0]   in_mant,
    input  logic [EB:0]   in_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MB:0]   out_mant,
    output logic [EB:0]   out_exp,
    output logic          out_ovf,
    output logic          out_denorm,
    output logic [3:0]    shift_cnt
);

    state_t      state, next_state;
    logic [MB:0] mant_q;
    logic [EB:0] exp_q;
    logic        ovf_q, denorm_q, valid_q;
    logic [3:0]  cnt_q;

    logic [MB:0] step_mant;
    logic [EB:0] step_exp;
    logic        step_ovf, step_denorm, step_shift, step_done;

    fp16_norm_sequencer_step #(.MB(MB), .EB(EB)) u_step (
        .mant      (mant_q),
        .exp       (exp_q),
        .next_mant (step_mant),
        .next_exp  (step_exp),
        .ovf       (step_ovf),
        .denorm    (step_denorm),
        .shift     (step_shift),
        .done      (step_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (in_valid) next_state = ST_NORM;
            ST_NORM: if (step_done) next_state = ST_DONE;
            ST_DONE: if (valid_q && out_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == ST_IDLE);
        out_valid  = valid_q;
        out_mant   = mant_q;
        out_exp    = exp_q;
        out_ovf    = ovf_q;
        out_denorm = denorm_q;
        shift_cnt  = cnt_q;
    end

    // Valid rises one cycle after entering DONE so the result is registered before it is offered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mant_q   <= '0;
            exp_q    <= '0;
            ovf_q    <= 1'b0;
            denorm_q <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        mant_q   <= in_mant;
                        exp_q    <= in_exp;
                        ovf_q    <= 1'b0;
                        denorm_q <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                ST_NORM: begin
                    mant_q   <= step_mant;
                    exp_q    <= step_exp;
                    ovf_q    <= step_ovf;
                    denorm_q <= step_denorm;
                    if (step_shift && (cnt_q != 4'hF)) cnt_q <= cnt_q + 4'd1;
                end
                ST_DONE: begin
                    if (!valid_q)      valid_q <= 1'b1;
                    else if (out_ready) valid_q <= 1'b0;
                end
                default: valid_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_norm_sequencer.sv
// Scoreboard bench for fp16_norm_sequencer: expected results are queued at accept time
// and compared when the sequencer offers its result.
module tb_fp16_norm_sequencer;

    typedef struct {
        logic [11:0] mant;
        logic [5:0]  exp;
        logic        ovf;
        logic        denorm;
        logic [3:0]  cnt;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [11:0] in_mant, out_mant;
    logic [5:0]  in_exp, out_exp;
    logic        out_ovf, out_denorm;
    logic [3:0]  shift_cnt;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    fp16_norm_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_ovf    (out_ovf),
        .out_denorm (out_denorm),
        .shift_cnt  (shift_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] m, input logic [5:0] e,
                                input logic o, input logic d, input logic [3:0] c);
        exp_t x;
        x.mant = m; x.exp = e; x.ovf = o; x.denorm = d; x.cnt = c;
        x.lat = 2 + int'(c);
        return x;
    endfunction

    // Closed-form reference: locate the leading one and decide how far it can travel.
    function automatic exp_t model(input logic [11:0] m, input logic [5:0] e);
        int pos, need, k;
        if (m == 12'd0) return mk(12'd0, 6'd0, 1'b0, 1'b0, 4'd0);
        if (e >= 6'd32 || (m[11] && int'(e) + 1 >= 31)) return mk(12'd0, 6'd31, 1'b1, 1'b0, 4'd0);
        if (m[11]) return mk(m >> 1, e + 6'd1, 1'b0, 1'b0, 4'd0);
        pos = 0;
        for (int i = 0; i < 11; i++) if (m[i]) pos = i;
        need = 10 - pos;
        if (need == 0) return mk(m, e, 1'b0, 1'b0, 4'd0);
        if (int'(e) - 1 >= need) return mk(m << need, e - 6'(need), 1'b0, 1'b0, 4'(need));
        k = (e > 6'd1) ? int'(e) - 1 : 0;
        return mk(m << k, 6'd0, 1'b0, 1'b1, 4'(k));
    endfunction

    task automatic applyStimulus(input logic [11:0] m, input logic [5:0] e, input exp_t x);
        checkOutput("ready before accept", in_ready, 1);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        sb.push_back(x);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("busy after accept", in_ready, 0);
    endtask

    task automatic collectResult(input int hold);
        exp_t x;
        int   lat;
        lat = 1;
        @(posedge clk); #1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        x = sb.pop_front();
        checkOutput("latency", lat, x.lat);
        checkOutput("out_mant", out_mant, x.mant);
        checkOutput("out_exp", out_exp, x.exp);
        checkOutput("out_ovf", out_ovf, x.ovf);
        checkOutput("out_denorm", out_denorm, x.denorm);
        checkOutput("shift_cnt", shift_cnt, x.cnt);
        in_valid = 1'b1;
        in_mant  = 12'h123;
        in_exp   = 6'd7;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput("hold valid", out_valid, 1);
            checkOutput("hold mant", out_mant, x.mant);
            checkOutput("hold exp", out_exp, x.exp);
            checkOutput("hold ovf", out_ovf, x.ovf);
            checkOutput("hold busy", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("valid drop", out_valid, 0);
        checkOutput("idle no accept", in_ready, 1);
    endtask

    initial begin
        logic [11:0] rm;
        logic [5:0]  re;
        int          seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mant = '0; in_exp = '0;
        #1;
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_mant", out_mant, 0);
        checkOutput("reset out_exp", out_exp, 0);
        checkOutput("reset flags", {out_ovf, out_denorm}, 0);
        checkOutput("reset shift_cnt", shift_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(12'h400, 6'd15, mk(12'h400, 6'd15, 1'b0, 1'b0, 4'd0)); collectResult(0);
        applyStimulus(12'h800, 6'd15, mk(12'h400, 6'd16, 1'b0, 1'b0, 4'd0)); collectResult(1);
        applyStimulus(12'h010, 6'd15, mk(12'h400, 6'd9,  1'b0, 1'b0, 4'd6)); collectResult(0);
        applyStimulus(12'h010, 6'd3,  mk(12'h040, 6'd0,  1'b0, 1'b1, 4'd2)); collectResult(0);
        applyStimulus(12'h000, 6'd9,  mk(12'h000, 6'd0,  1'b0, 1'b0, 4'd0)); collectResult(0);
        applyStimulus(12'h800, 6'd30, mk(12'h000, 6'd31, 1'b1, 1'b0, 4'd0)); collectResult(5);
        applyStimulus(12'h200, 6'd1,  mk(12'h200, 6'd0,  1'b0, 1'b1, 4'd0)); collectResult(0);
        applyStimulus(12'h001, 6'd40, mk(12'h000, 6'd31, 1'b1, 1'b0, 4'd0)); collectResult(0);
        applyStimulus(12'h800, 6'd29, mk(12'h400, 6'd30, 1'b0, 1'b0, 4'd0)); collectResult(0);
        applyStimulus(12'h001, 6'd20, mk(12'h400, 6'd10, 1'b0, 1'b0, 4'd10)); collectResult(0);

        applyStimulus(12'h001, 6'd15, model(12'h001, 6'd15));
        sb.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort in_ready", in_ready, 1);
        checkOutput("abort out_valid", out_valid, 0);
        checkOutput("abort shift_cnt", shift_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        checkOutput("no valid after abort", seen, 0);

        for (int i = 0; i < 12; i++) begin
            rm = 12'($urandom_range(0, 4095));
            re = 6'($urandom_range(0, 35));
            if (i < 4) rm = rm >> (3 * i);
            applyStimulus(rm, re, model(rm, re));
            collectResult(i % 3);
        end

        checkOutput("scoreboard empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
